muldiv_unit: RTL

Iterative multi-cycle multiply/divide unit for the RV32M instructions, sitting in the EX stage beside the combinational ALU. It takes its operands and operation code from the same ID/EX outputs that feed the ALU, using the shared ALU control encoding. It runs a fixed-latency shift-add or restoring-division sequence. Its registered result goes to the writeback mux, and `busy` stalls the pipeline front end while it runs.

---
 rtl/muldiv_unit_pkg.sv | 34 +++
 rtl/muldiv_unit_if.sv | 14 +
 rtl/muldiv_unit_negate.sv | 10 +
 rtl/muldiv_unit.sv | 115 +++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared ALU control encodings plus muldiv_unit state type and op-class helpers.
package muldiv_unit_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } md_state_e;

    function automatic logic is_mdop(input logic [4:0] op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_divop(input logic [4:0] op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and muldiv_unit.
interface muldiv_if;
    logic        start;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (output start, op, a, b, flush, input busy, done, result);
    modport slave  (input start, op, a, b, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_unit_negate.sv
// Combinational conditional two's-complement negation.
module muldiv_negate #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);
    assign y = neg ? (~x + W'(1)) : x;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-division steps,
// one sign-fix cycle, then a single-cycle done pulse.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);

    md_state_e       state_q, state_d;
    logic [4:0]      op_q;
    logic            sa_q, sb_q;
    logic [XLEN-1:0] mb_q, hi_q, lo_q, result_q;
    logic [4:0]      cnt_q;

    logic            sa_in, sb_in, accept;
    logic [XLEN-1:0] ma_in, mb_in;

    assign sa_in  = bus.a[XLEN-1] & (bus.op inside {ALU_DIV, ALU_REM, ALU_MULH, ALU_MULHSU});
    assign sb_in  = bus.b[XLEN-1] & (bus.op inside {ALU_DIV, ALU_REM, ALU_MULH});
    assign accept = (state_q == S_IDLE) && bus.start && is_mdop(bus.op) && !bus.flush;

    muldiv_negate #(.W(XLEN)) u_neg_a (.x(bus.a), .neg(sa_in), .y(ma_in));
    muldiv_negate #(.W(XLEN)) u_neg_b (.x(bus.b), .neg(sb_in), .y(mb_in));

    logic [XLEN:0]   mul_sum, rem_sh;
    logic [XLEN-1:0] rem_sub;
    logic            div_ge;

    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
    assign rem_sh  = {hi_q, lo_q[XLEN-1]};
    assign div_ge  = rem_sh >= {1'b0, mb_q};
    assign rem_sub = rem_sh[XLEN-1:0] - mb_q;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    muldiv_negate #(.W(2*XLEN)) u_neg_p (.x({hi_q, lo_q}), .neg(sa_q ^ sb_q), .y(prod_fix));
    muldiv_negate #(.W(XLEN))   u_neg_q (.x(lo_q), .neg(sa_q ^ sb_q), .y(quo_fix));
    muldiv_negate #(.W(XLEN))   u_neg_r (.x(hi_q), .neg(sa_q), .y(rem_fix));

    // Divide by zero leaves rem=|a|, so rem_fix already equals a; signed overflow
    // (0x80000000 / -1) falls out of the magnitude path as 0x80000000 rem 0.
    always_comb begin
        fix_res = prod_fix[XLEN-1:0];
        case (op_q)
            ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:               fix_res = (mb_q == '0) ? '1 : quo_fix;
            ALU_REM, ALU_REMU:               fix_res = rem_fix;
            default:                         fix_res = prod_fix[XLEN-1:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CALC;
            S_CALC:  if (cnt_q == 5'd31) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            mb_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    op_q  <= bus.op;
                    sa_q  <= sa_in;
                    sb_q  <= sb_in;
                    mb_q  <= mb_in;
                    hi_q  <= '0;
                    lo_q  <= ma_in;
                    cnt_q <= '0;
                end
                S_CALC: begin
                    if (is_divop(op_q)) begin
                        hi_q <= div_ge ? rem_sub : rem_sh[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], div_ge};
                    end else begin
                        hi_q <= mul_sum[XLEN:1];
                        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    cnt_q <= cnt_q + 5'd1;
                end
                S_FIX: if (!bus.flush) result_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE) && !bus.flush;
    assign bus.result = result_q;

endmodule
